// File: rtl/counter_load_queue.sv
// counter_load_queue: in-order queue of load requests driving a loadable counter with spaced, optionally terminal-count-aligned pulses.
// Define LOADQ_FLUSH_EN to add flush_i, which empties the queue.
module counter_load_queue #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int MIN_GAP = 2
) (
    input  logic                       clk,
    input  logic                       reset,
`ifdef LOADQ_FLUSH_EN
    input  logic                       flush_i,
`endif
    input  logic                       req_valid_i,
    input  logic [WIDTH-1:0]           req_val_i,
    output logic                       req_ready_o,
    input  logic                       align_i,
    input  logic [WIDTH-1:0]           count_i,
    output logic                       load_o,
    output logic [WIDTH-1:0]           load_val_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] load_val_q, load_val_d;
    logic             flush, push, pop;

`ifdef LOADQ_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Ready looks only at the registered level; a same-cycle pop never frees a slot early.
    assign req_ready_o = (level_q < LW'(DEPTH)) && !flush;
    assign push        = req_valid_i && req_ready_o;
    assign pop         = (level_q != '0) && (gap_q == '0) && (!align_i || (&count_i)) && !flush;

    always_comb begin
        wr_ptr_d   = flush ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = flush ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = flush ? '0 : (push && !pop) ? level_q + LW'(1) : (pop && !push) ? level_q - LW'(1) : level_q;
        gap_d      = flush ? '0 : pop ? GW'(MIN_GAP - 1) : (gap_q != '0) ? gap_q - GW'(1) : gap_q;
        load_d     = pop;
        load_val_d = pop ? mem_q[rd_ptr_q] : load_val_q;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= req_val_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            gap_q      <= '0;
            load_q     <= 1'b0;
            load_val_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            gap_q      <= gap_d;
            load_q     <= load_d;
            load_val_q <= load_val_d;
        end
    end

    assign load_o     = load_q;
    assign load_val_o = load_val_q;
    assign level_o    = level_q;
endmodule
